// File: rtl/noc_sequencer_pkg.sv
// noc_sequencer_pkg: op codes, op width and FSM state encoding shared by the NoC sequencer and its users
package noc_sequencer_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_NOP         = 4'd0,
    OP_PHASE0      = 4'd1,
    OP_PHASE1      = 4'd2,
    OP_LOADSTAGING = 4'd3,
    OP_LOADRT      = 4'd4,
    OP_INIT        = 4'd5,
    OP_FILL        = 4'd6,
    OP_DEQUEUE     = 4'd7,
    OP_PREDEQUE    = 4'd8
  } op_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_TRAFFIC,
    S_FILL,
    S_PRE_DEQUE,
    S_INIT_ROUTER,
    S_LOAD_RT,
    S_LOAD_STAGING,
    S_PHASE0,
    S_PHASE1,
    S_CHECK_END,
    S_DONE
  } state_e;
endpackage

// File: rtl/noc_sequencer.sv
// noc_sequencer: run sequencer for a NoC simulator (fill, route load, 4-clock network cycles, end check).
// Define NOC_TIMEOUT_EN to end a run once in_cycle reaches max_cycle.
module noc_sequencer
  import noc_sequencer_pkg::*;
#(
  parameter int ROUTER_SIZE = 16,
  parameter int CYCLE_W = 16,
  parameter int FILL_MAX = 1024,
  localparam int RD_W = $clog2(ROUTER_SIZE),
  localparam int FI_W = $clog2(FILL_MAX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CYCLE_W-1:0]     max_cycle,
  input  logic [ROUTER_SIZE-1:0] fill_req,
  input  logic [ROUTER_SIZE-1:0] rt_valid,
  input  logic [ROUTER_SIZE-1:0] inject_ok,
  input  logic [ROUTER_SIZE-1:0] router_done,
  output logic [OP_W-1:0]        router_op,
  output logic [ROUTER_SIZE-1:0] router_op_en,
  output logic [OP_W-1:0]        traffic_op,
  output logic [ROUTER_SIZE-1:0] traffic_op_en,
  output logic [RD_W-1:0]        rt_dst,
  output logic [FI_W-1:0]        fill_idx,
  output logic [CYCLE_W-1:0]     in_cycle,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout
);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(ROUTER_SIZE - 1);
  localparam logic [FI_W-1:0] FI_LAST = FI_W'(FILL_MAX - 1);
  state_e               r_state;
  logic [RD_W-1:0]      r_rt_dst;
  logic [FI_W-1:0]      r_fill_idx;
  logic [CYCLE_W-1:0]   r_in_cycle;
  logic                 r_finished;
  logic                 r_timeout;
  logic                 w_all_done;
  logic                 w_tmo;
  assign w_all_done = &router_done;
`ifdef NOC_TIMEOUT_EN
  assign w_tmo = r_in_cycle >= max_cycle;
`else
  assign w_tmo = 1'b0 & |max_cycle;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rt_dst   <= '0;
      r_fill_idx <= '0;
      r_in_cycle <= '0;
      r_finished <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state    <= S_INIT_TRAFFIC;
          r_rt_dst   <= '0;
          r_fill_idx <= '0;
          r_in_cycle <= '0;
          r_finished <= 1'b0;
          r_timeout  <= 1'b0;
        end
        S_INIT_TRAFFIC: r_state <= S_FILL;
        S_FILL: begin
          if (r_fill_idx != FI_LAST) r_fill_idx <= r_fill_idx + 1'b1;
          if (fill_req == '0 || r_fill_idx == FI_LAST) r_state <= S_PRE_DEQUE;
        end
        S_PRE_DEQUE: r_state <= S_INIT_ROUTER;
        S_INIT_ROUTER: r_state <= S_LOAD_RT;
        S_LOAD_RT: begin
          if (r_rt_dst == RD_LAST) r_state <= S_LOAD_STAGING;
          else r_rt_dst <= r_rt_dst + 1'b1;
        end
        S_LOAD_STAGING: r_state <= S_PHASE0;
        S_PHASE0: r_state <= S_PHASE1;
        S_PHASE1: begin
          r_in_cycle <= r_in_cycle + {{(CYCLE_W-1){1'b0}}, ~&r_in_cycle};
          r_state    <= S_CHECK_END;
        end
        S_CHECK_END: begin
          // completion wins over a timeout seen in the same cycle
          r_state    <= (w_all_done || w_tmo) ? S_DONE : S_LOAD_STAGING;
          r_finished <= w_all_done;
          r_timeout  <= !w_all_done && w_tmo;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    router_op     = OP_NOP;
    router_op_en  = '0;
    traffic_op    = OP_NOP;
    traffic_op_en = '0;
    case (r_state)
      S_INIT_TRAFFIC: begin traffic_op = OP_INIT;     traffic_op_en = '1;       end
      S_FILL:         begin traffic_op = OP_FILL;     traffic_op_en = fill_req; end
      S_PRE_DEQUE:    begin traffic_op = OP_PREDEQUE; traffic_op_en = '1;       end
      S_INIT_ROUTER:  begin router_op  = OP_INIT;     router_op_en  = '1;       end
      S_LOAD_RT:      begin router_op  = OP_LOADRT;   router_op_en  = rt_valid; end
      S_LOAD_STAGING: begin
        router_op     = OP_LOADSTAGING;
        router_op_en  = '1;
        traffic_op    = OP_DEQUEUE;
        traffic_op_en = inject_ok;
      end
      S_PHASE0:       begin router_op  = OP_PHASE0;   router_op_en  = '1;       end
      S_PHASE1:       begin router_op  = OP_PHASE1;   router_op_en  = '1;       end
      default: ;
    endcase
  end
  assign rt_dst   = r_rt_dst;
  assign fill_idx = r_fill_idx;
  assign in_cycle = r_in_cycle;
  assign busy     = !(r_state == S_IDLE || r_state == S_DONE);
  assign finished = r_finished;
  assign timeout  = r_timeout;
endmodule

// File: tb/tb_noc_sequencer.sv
// tb_noc_sequencer: builds expected per-clock traces of whole runs from the phase rules, replays them against the DUT
module tb_noc_sequencer;
  import noc_sequencer_pkg::*;
  localparam int RS = 4;
  localparam int CW = 4;
  localparam int FM = 8;
  localparam int SAT = (1 << CW) - 1;
`ifdef NOC_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start;
  logic [CW-1:0] max_cycle;
  logic [RS-1:0] fill_req, rt_valid, inject_ok, router_done;
  logic [OP_W-1:0] router_op, traffic_op;
  logic [RS-1:0] router_op_en, traffic_op_en;
  logic [1:0] rt_dst;
  logic [2:0] fill_idx;
  logic [CW-1:0] in_cycle;
  logic busy, finished, timeout;
  always #5 clk = ~clk;
  noc_sequencer #(.ROUTER_SIZE(RS), .CYCLE_W(CW), .FILL_MAX(FM)) dut (
    .clk(clk), .rst(rst), .start(start), .max_cycle(max_cycle),
    .fill_req(fill_req), .rt_valid(rt_valid), .inject_ok(inject_ok), .router_done(router_done),
    .router_op(router_op), .router_op_en(router_op_en), .traffic_op(traffic_op),
    .traffic_op_en(traffic_op_en), .rt_dst(rt_dst), .fill_idx(fill_idx), .in_cycle(in_cycle),
    .busy(busy), .finished(finished), .timeout(timeout)
  );
  typedef struct {
    logic start;
    logic [3:0] mc, fill_req, rt_valid, inject_ok, router_done;
    logic [3:0] r_op, r_en, t_op, t_en;
    logic [1:0] dst;
    logic [2:0] fi;
    logic chk_dst, chk_fi;
    logic [3:0] ic;
    logic busy, fin, to;
  } vec_t;
  vec_t q[$];
  int n_vec = 0, n_err = 0;
  int m_ic = 0, cur_mc = 0;
  bit m_fin = 0, m_to = 0;
  function automatic vec_t blank(input logic b);
    vec_t v;
    v.start = b ? 1'($urandom) : 1'b0;
    v.mc = 4'(cur_mc);
    v.fill_req = 4'($urandom);
    v.rt_valid = 4'($urandom);
    v.inject_ok = 4'($urandom);
    v.router_done = 4'($urandom_range(0, 14));
    v.r_op = OP_NOP; v.r_en = 4'h0; v.t_op = OP_NOP; v.t_en = 4'h0;
    v.dst = 2'd0; v.fi = 3'd0; v.chk_dst = 1'b0; v.chk_fi = 1'b0;
    v.ic = 4'(m_ic); v.busy = b;
    v.fin = b ? 1'b0 : m_fin;
    v.to = b ? 1'b0 : m_to;
    return v;
  endfunction
  // One full run: launch, fill for F requesting cycles, route load, network cycles until done at D or timeout at mc
  task automatic gen_run(input int F, input logic [3:0] fixed_req, input logic [3:0] rtv, input int D, input int mc);
    vec_t v;
    logic [3:0] fr;
    bit dn, tmo;
    cur_mc = mc;
    v = blank(1'b0); v.start = 1'b1; q.push_back(v);
    m_ic = 0; m_fin = 0; m_to = 0;
    v = blank(1'b1); v.t_op = OP_INIT; v.t_en = 4'hF; q.push_back(v);
    for (int k = 0; ; k++) begin
      fr = (k < F) ? ((fixed_req != 0) ? fixed_req : 4'($urandom_range(1, 15))) : 4'h0;
      v = blank(1'b1); v.fill_req = fr; v.t_op = OP_FILL; v.t_en = fr;
      v.fi = 3'(k); v.chk_fi = 1'b1; q.push_back(v);
      if (fr == 0 || k == FM - 1) break;
    end
    v = blank(1'b1); v.t_op = OP_PREDEQUE; v.t_en = 4'hF; q.push_back(v);
    v = blank(1'b1); v.r_op = OP_INIT; v.r_en = 4'hF; q.push_back(v);
    for (int d = 0; d < RS; d++) begin
      v = blank(1'b1); v.rt_valid = rtv; v.r_op = OP_LOADRT; v.r_en = rtv;
      v.dst = 2'(d); v.chk_dst = 1'b1; q.push_back(v);
    end
    for (int n = 1; ; n++) begin
      v = blank(1'b1); v.r_op = OP_LOADSTAGING; v.r_en = 4'hF; v.t_op = OP_DEQUEUE;
      v.t_en = v.inject_ok; q.push_back(v);
      v = blank(1'b1); v.r_op = OP_PHASE0; v.r_en = 4'hF; q.push_back(v);
      v = blank(1'b1); v.r_op = OP_PHASE1; v.r_en = 4'hF; q.push_back(v);
      m_ic = (m_ic < SAT) ? m_ic + 1 : SAT;
      dn = (n >= D);
      tmo = TEN && !dn && (m_ic >= mc);
      v = blank(1'b1); if (dn) v.router_done = 4'hF; q.push_back(v);
      if (dn) m_fin = 1; else if (tmo) m_to = 1;
      if (dn || tmo) break;
    end
    for (int i = 0; i < 2; i++) q.push_back(blank(1'b0));
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] outs(input logic md, input logic mf);
    return {4'h0, router_op, router_op_en, traffic_op, traffic_op_en,
            md ? rt_dst : 2'd0, mf ? fill_idx : 3'd0, in_cycle, busy, finished, timeout};
  endfunction
  initial begin
    bit hit;
    rst = 1'b1; start = 1'b0; max_cycle = '0;
    fill_req = '0; rt_valid = '0; inject_ok = '0; router_done = '0;
    gen_run(3, 4'b0011, 4'b1010, 1, 0);
    if (TEN) gen_run(0, 4'h0, 4'hF, 1000, 3);
    gen_run(2, 4'h0, 4'h5, 18, 15);
    gen_run(10, 4'h0, 4'h3, 2, 6);
    for (int r = 0; r < 8; r++)
      gen_run($urandom_range(0, 10), 4'h0, 4'($urandom), $urandom_range(1, 6), $urandom_range(0, 6));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_state", outs(1'b1, 1'b1), 32'h0);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      start = q[i].start; max_cycle = q[i].mc; fill_req = q[i].fill_req;
      rt_valid = q[i].rt_valid; inject_ok = q[i].inject_ok; router_done = q[i].router_done;
      #1 check($sformatf("vec%0d", i), outs(q[i].chk_dst, q[i].chk_fi),
               {4'h0, q[i].r_op, q[i].r_en, q[i].t_op, q[i].t_en, q[i].dst, q[i].fi,
                q[i].ic, q[i].busy, q[i].fin, q[i].to});
    end
    @(posedge clk);
    #1 start = 1'b1; fill_req = '0; router_done = '0;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk);
      #2 start = 1'b0;
      hit = (router_op == OP_PHASE0);
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL reach_phase0: got no PHASE0 want PHASE0 within 50 clocks"); end
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #2 check("rst_mid_run", outs(1'b1, 1'b1), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #2 start = 1'b0;
    check("restart_init", outs(1'b1, 1'b1),
          {4'h0, 4'(OP_NOP), 4'h0, 4'(OP_INIT), 4'hF, 2'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
